// File: rtl/piso_transmitter.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, supporting gapless back-to-back frames.
module piso_transmitter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-2:0] rest_bits;
  logic [WIDTH-2:0] sreg_adv;

  // Bit-order selection: the shift register always holds the bits still to be sent.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit = din[WIDTH-1];
      rest_bits = din[WIDTH-2:0];
      next_bit  = sreg_q[WIDTH-2];
      sreg_adv  = sreg_q << 1;
    end else begin
      first_bit = din[0];
      rest_bits = din[WIDTH-1:1];
      next_bit  = sreg_q[0];
      sreg_adv  = sreg_q >> 1;
    end
  end

  assign load_ready = (state_q == IDLE) || (cnt_q == '0);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        so_d = 1'b0;
        if (accept) begin
          so_d    = first_bit;
          sreg_d  = rest_bits;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          so_d   = next_bit;
          sreg_d = sreg_adv;
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          done_d = 1'b1;
          if (accept) begin
            // Reload straight from the last bit so the stream has no gap.
            so_d   = first_bit;
            sreg_d = rest_bits;
            cnt_d  = CNT_W'(WIDTH - 1);
          end else begin
            so_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign so   = so_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: doc/piso_transmitter.md
Name: piso_transmitter

Overview:
Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a single serial line. It is the source end for the serial chains in the registers library, producing the serial bit stream that serial-in registers consume. It supports back-to-back words with no idle gap between frames.

Parameters:
WIDTH, 8, word length in bits; must be at least 2.
MSB_FIRST, 0, 0 sends bit 0 first (LSB-first); 1 sends bit WIDTH-1 first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
load_valid  input  1  din holds a word to send.
din  input  WIDTH  parallel word.
load_ready  output  1  the transmitter can accept a word this cycle.
so  output  1  serial data out, registered.
busy  output  1  a frame is being shifted.
done  output  1  one-cycle pulse after the last bit of a frame has been presented.

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE, shift register=0, bit counter=0.
  - so=0, busy=0, done=0, load_ready=1 (combinational from state).
  - Reset takes priority over all other inputs.
- Reset mid-frame aborts the frame: the remaining bits are lost and no done pulse is issued.
- States are IDLE and SHIFT. The counter width is clog2(WIDTH).
- Accept = load_valid && load_ready at a rising edge.
- load_ready rules:
  - 1 in IDLE.
  - 1 in SHIFT only when counter==0, i.e. the last bit is on so.
  - 0 otherwise.
- load_valid while load_ready=0 is ignored. din is not sampled and nothing is queued.
- IDLE:
  - so=0, busy=0.
  - On accept: so<=first bit of din, shift register<=remaining WIDTH-1 bits, counter<=WIDTH-1, go to SHIFT.
- SHIFT, busy=1:
  - counter!=0: so<=next bit, shift register advances one position, counter decrements.
  - counter==0 with no accept: go to IDLE, so<=0, done<=1.
  - counter==0 with accept: stay in SHIFT, load the new word exactly as from IDLE, done<=1. The stream stays continuous with no gap bit.
- Latency and frame timing:
  - The first bit appears on so in the cycle after the accept edge.
  - Bit k is on so for exactly one cycle, cycle k+1 after the accept.
  - A frame occupies WIDTH cycles.
  - done is high in the cycle immediately after the last bit's cycle.
- done is high for exactly one cycle per completed frame. It is never asserted after reset without a completed frame.
- Bit order:
  - MSB_FIRST=0: din[0], din[1], …, din[WIDTH-1].
  - MSB_FIRST=1: reverse order.
- din may change freely after the accept edge. The captured word is unaffected.

Test Plan:
- Reset: hold rst=1 for 2 cycles with load_valid=1 -> so=0, busy=0, done=0, load_ready=1; no capture occurs.
- Single word, WIDTH=8, LSB-first: din=8'hA5 accepted at edge 0 -> so = 1,0,1,0,0,1,0,1 in cycles 1–8; busy=1 in cycles 1–8; done=1 only in cycle 9; so=0 and load_ready=1 in cycle 9.
- Back-to-back streaming: present 8'hA5 and then 8'h3C with load_valid held high -> the second word is accepted in cycle 8; so = A5 bits followed immediately by 0,0,1,1,1,1,0,0 with no gap; done pulses in cycles 9 and 17.
- Ignored load: load_valid=1 with din=8'hFF during cycles 2–6 of an 8'h00 frame -> so stays 0 for all 8 bits; exactly one done pulse.
- MSB_FIRST=1, WIDTH=32, din=32'hC6EF15AD -> so = 1,1,0,0,0,1,1,0,… (MSB down to LSB) over 32 cycles; done in cycle 33.
- Reset mid-frame: assert rst in cycle 4 of an 8'hA5 frame -> so=0, busy=0 next cycle; no done pulse; the next accepted word transmits normally.
